// File: rtl/divider_seq_hs.sv
// Sequential restoring divider, one quotient bit per clock, start/busy/done handshake.
// Define SIGNED_DIV_EN to add the signed_op port and two's-complement division.
module divider_seq_hs #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
`ifdef SIGNED_DIV_EN
  input  logic             signed_op,
`endif
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_ITER   = 3'd2,
    S_FINISH = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   dvnd_q;
  logic [WIDTH-1:0]   dvsr_q;
  logic [WIDTH-1:0]   raw_dvnd_q;
  logic               neg_quo_q;
  logic               neg_rem_q;
  logic               busy_q;
  logic               done_q;
  logic               error_q;
  logic [WIDTH-1:0]   quotient_q;
  logic [WIDTH-1:0]   remainder_q;

  logic               op_signed;
  logic [WIDTH-1:0]   dvnd_mag_d;
  logic [WIDTH-1:0]   dvsr_mag_d;
  logic [WIDTH:0]     shift_d;
  logic [WIDTH:0]     trial_d;

`ifdef SIGNED_DIV_EN
  assign op_signed = signed_op;
`else
  assign op_signed = 1'b0;
`endif

  // Magnitudes of the raw operands; MIN maps onto itself, which is its correct unsigned magnitude.
  always_comb begin
    dvnd_mag_d = dividend;
    dvsr_mag_d = divisor;
    if (op_signed && dividend[WIDTH-1]) dvnd_mag_d = -dividend;
    if (op_signed && divisor[WIDTH-1])  dvsr_mag_d = -divisor;
  end

  // WIDTH+1-bit trial subtraction keeps full-scale operands from overflowing.
  always_comb begin
    shift_d = {rem_q, dvnd_q[WIDTH-1]};
    trial_d = shift_d - {1'b0, dvsr_q};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      dvnd_q      <= '0;
      dvsr_q      <= '0;
      raw_dvnd_q  <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            dvnd_q     <= dvnd_mag_d;
            dvsr_q     <= dvsr_mag_d;
            raw_dvnd_q <= dividend;
            neg_quo_q  <= op_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_rem_q  <= op_signed && dividend[WIDTH-1];
            busy_q     <= 1'b1;
            state_q    <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (dvsr_q == '0) begin
            quotient_q  <= '1;
            remainder_q <= raw_dvnd_q;
            done_q      <= 1'b1;
            error_q     <= 1'b1;
            state_q     <= S_ERR;
          end else begin
            cnt_q   <= CNT_W'(WIDTH - 1);
            rem_q   <= '0;
            state_q <= S_ITER;
          end
        end
        S_ITER: begin
          // Quotient bits shift in behind the dividend bits as they are consumed.
          if (!trial_d[WIDTH]) rem_q <= trial_d[WIDTH-1:0];
          else                 rem_q <= shift_d[WIDTH-1:0];
          dvnd_q <= {dvnd_q[WIDTH-2:0], ~trial_d[WIDTH]};
          if (cnt_q == '0) state_q <= S_FINISH;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        S_FINISH: begin
          quotient_q  <= neg_quo_q ? -dvnd_q : dvnd_q;
          remainder_q <= neg_rem_q ? -rem_q  : rem_q;
          done_q      <= 1'b1;
          state_q     <= S_DONE;
        end
        S_DONE, S_ERR: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule
